csa_slice_sequencer: RTL and testbench
======================================

CSA_SLICE_SEQUENCER -- requirements
Module: csa_slice_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 4: bits added per cycle; N = WIDTH/SLICE compute cycles.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  2  per-requester operation request; bit i is requester i.
REQ-006 req_ready  output  2  per-requester grant; a handshake occurs when req_valid[i] and req_ready[i] are both 1.
REQ-007 a0, b0 / a1, b1  input  WIDTH each  operands of requester 0 / requester 1.
REQ-008 cin  input  2  carry-in per requester.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  result consumer accepts.
REQ-011 res_sum  output  WIDTH  a + b + cin modulo 2^WIDTH.
REQ-012 res_cout  output  1  carry out of bit WIDTH-1.
REQ-013 res_id  output  1  index of the requester that owns the result.
REQ-014 res_skip_cnt  output  clog2(N+1)  number of slices whose group propagate was all-ones.

Function
REQ-015 States: IDLE, CALC, DONE.
REQ-016 IDLE: req_ready SHALL be one-hot to the granted requester when any req_valid is 1, else 0; it SHALL be 0 in CALC and DONE.
REQ-017 Arbitration: with one valid requester, that requester SHALL be granted; with both valid, the requester at round-robin pointer rr SHALL be granted.
REQ-018 After each handshake, rr SHALL point to the non-granted requester.
REQ-019 On handshake, operands, cin, and id SHALL be latched, slice index k = 0, skip count = 0, and state -> CALC.
REQ-020 In CALC, one slice per cycle, k = 0..N-1.
REQ-021 Slice k SHALL compute p = a^b over bits [k*SLICE +: SLICE], bp = AND of p, and sum bits.
REQ-022 Slice carry-out SHALL be the incoming carry when bp = 1 (skip path), else the slice ripple carry.
REQ-023 The carry SHALL be registered between slices.
REQ-024 When bp = 1, the skip count SHALL increment.
REQ-025 After slice N-1, state -> DONE; res_valid SHALL rise exactly N+1 cycles after the handshake cycle.
REQ-026 DONE: res_valid = 1, and res_sum/res_cout/res_id/res_skip_cnt SHALL hold stable until res_valid and res_ready are both 1.
REQ-027 On that cycle, state -> IDLE, with no new grant in the same cycle; sustained throughput is one operation per N+2 cycles.
REQ-028 Request-side inputs changing during CALC or DONE SHALL NOT affect the in-flight result.
REQ-029 res_ready asserted while res_valid = 0 SHALL be ignored.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, rr = 0, res_valid = 0, req_ready = 0, res_sum = 0, res_cout = 0, res_id = 0, res_skip_cnt = 0, k = 0.
REQ-031 Reset asserted mid-CALC or mid-DONE SHALL discard the operation; no res_valid SHALL follow.
REQ-032 Operation SHALL resume on the first clock edge after rst_n rises.

Structure
REQ-033 Shared package csa_pkg SHALL hold WIDTH/SLICE defaults and the state enum type.
REQ-034 Sub-module csa_slice (SLICE-bit a, b, cin -> sum, group propagate, skip-muxed cout) SHALL be instantiated once and time-multiplexed.

Verification
REQ-035 Requester 0 only: a0 = 0xFFFF, b0 = 0x0001, cin0 = 0 -> res_sum = 0x0000, res_cout = 1, res_skip_cnt = 3, res_id = 0, res_valid 5 cycles after handshake.
REQ-036 Requester 1 only: a1 = 0x1234, b1 = 0x4321, cin1 = 1 -> res_sum = 0x5556, res_cout = 0, res_skip_cnt = 0, res_id = 1.
REQ-037 Both valid from reset -> requester 0 granted first, requester 1 second; with both still valid, grants alternate 0, 1, 0, 1.
REQ-038 res_ready held low 5 cycles in DONE -> all result outputs stable, req_ready stays 0, completion occurs on the first res_ready = 1.
REQ-039 rst_n pulsed low during CALC slice 2 -> all outputs at reset values asynchronously, no result issued, next request completes correctly.
REQ-040 a = 0xFFFF, b = 0x0000, cin = 1 -> res_sum = 0x0000, res_cout = 1, res_skip_cnt = 4, i.e. the carry travels entirely on the skip path.

Source files
------------

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared defaults, state type and arbitration helper for the carry-skip sequencer
package csa_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One-hot grant: a lone requester always wins, a tie goes to the rr pointer.
  function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic rr);
    case (valid)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return rr ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/csa_slice.sv
// rtl/csa_slice.sv - one carry-skip adder slice with group propagate and skip-muxed carry out
module csa_slice
  import csa_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             bp,
  output logic             cout
);

  logic [SLICE:0] ripple;

  assign ripple = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  assign sum    = ripple[SLICE-1:0];
  assign bp     = &(a ^ b);
  // When every bit propagates the incoming carry bypasses the ripple chain.
  assign cout   = bp ? cin : ripple[SLICE];

endmodule

// File: rtl/csa_slice_sequencer.sv
// rtl/csa_slice_sequencer.sv - two-requester adder that walks one carry-skip slice per cycle
module csa_slice_sequencer
  import csa_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int SLICE = DEF_SLICE,
  localparam int N     = WIDTH / SLICE,
  localparam int CW    = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic [CW-1:0]    res_skip_cnt
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_t           state, state_nxt;
  logic             rr;
  logic [1:0]       grant;
  logic [1:0]       ready_c;
  logic             hs;
  logic             last;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [KW-1:0]    k;
  logic             carry_q;
  logic             id_q;
  logic [CW-1:0]    skip_q;
  logic [SLICE-1:0] s_a, s_b, s_sum;
  logic             s_bp, s_cout;

  assign grant = rr_grant(req_valid, rr);
  assign last  = (k == KW'(N - 1));
  assign hs    = (state == ST_IDLE) && (|grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 2'b00;
    case (state)
      ST_IDLE: begin
        ready_c = grant;
        if (|grant) state_nxt = ST_CALC;
      end
      ST_CALC: if (last) state_nxt = ST_DONE;
      ST_DONE: if (res_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant is combinational from IDLE, so it is gated to drop the moment reset asserts.
  assign req_ready = rst_n ? ready_c : 2'b00;

  assign s_a = a_q[k*SLICE +: SLICE];
  assign s_b = b_q[k*SLICE +: SLICE];

  csa_slice #(.SLICE(SLICE)) u_slice (
    .a   (s_a),
    .b   (s_b),
    .cin (carry_q),
    .sum (s_sum),
    .bp  (s_bp),
    .cout(s_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr      <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k       <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      skip_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (hs) begin
          a_q     <= grant[1] ? a1 : a0;
          b_q     <= grant[1] ? b1 : b0;
          carry_q <= grant[1] ? cin[1] : cin[0];
          id_q    <= grant[1];
          rr      <= ~grant[1];
          sum_q   <= '0;
          k       <= '0;
          skip_q  <= '0;
        end
        ST_CALC: begin
          sum_q[k*SLICE +: SLICE] <= s_sum;
          carry_q                 <= s_cout;
          if (s_bp) skip_q <= skip_q + 1'b1;
          k <= last ? '0 : k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign res_valid    = (state == ST_DONE);
  assign res_sum      = sum_q;
  assign res_cout     = carry_q;
  assign res_id       = id_q;
  assign res_skip_cnt = skip_q;

endmodule

// File: tb/tb_csa_slice_sequencer.sv
// tb/tb_csa_slice_sequencer.sv - randomized self-checking bench for csa_slice_sequencer
module tb_csa_slice_sequencer;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int N     = WIDTH / SLICE;
  localparam int CW    = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]       cin = 2'b00;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_id;
  logic [CW-1:0]    res_skip_cnt;

  int   checks = 0;
  int   errors = 0;
  logic model_rr = 1'b0;

  always #5 clk = ~clk;

  csa_slice_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin(cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_id(res_id), .res_skip_cnt(res_skip_cnt)
  );

  // Reference: full-width arithmetic sum, skip count from slices of a^b that are all ones.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                       output logic [WIDTH-1:0] s, output logic co, output logic [CW-1:0] sk);
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] x;
    int               n;
    t  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    s  = t[WIDTH-1:0];
    co = t[WIDTH];
    x  = a ^ b;
    n  = 0;
    for (int i = 0; i < N; i++)
      if (((x >> (i * SLICE)) & WIDTH'((1 << SLICE) - 1)) == WIDTH'((1 << SLICE) - 1)) n++;
    sk = CW'(n);
  endtask

  task automatic start_op(input logic [1:0] v, input logic [WIDTH-1:0] xa0, input logic [WIDTH-1:0] xb0,
                          input logic [WIDTH-1:0] xa1, input logic [WIDTH-1:0] xb1, input logic [1:0] xc,
                          output logic [1:0] g, output bit ok);
    ok = 1'b0;
    g  = 2'b00;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      req_valid = v; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1; cin = xc;
      #1;
      g  = req_ready;
      ok = (g != 2'b00);
    end
    if (ok) begin
      @(posedge clk);
      #1;
      a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
      cin = 2'($urandom);
    end
  endtask

  task automatic wait_result(output int lat, output logic [WIDTH-1:0] s, output logic co,
                             output logic id, output logic [CW-1:0] sk);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (res_valid) lat = i;
    end
    s = res_sum; co = res_cout; id = res_id; sk = res_skip_cnt;
    res_ready = 1'b0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req_valid = 2'b11;
    res_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_req_ready got %b want 00", req_ready);
    end
    checks++;
    if ({res_valid, res_sum, res_cout, res_id, res_skip_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b sum=%h cout=%b id=%b skip=%0d want all 0",
               res_valid, res_sum, res_cout, res_id, res_skip_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    res_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_arbitration();
    logic [1:0] g, c, gexp;
    bit ok;
    int lat;
    logic [WIDTH-1:0] x0, y0, x1, y1, s, es;
    logic co, id, eco;
    logic [CW-1:0] sk, esk;
    for (int i = 0; i < 4; i++) begin
      x0 = 16'($urandom); y0 = 16'($urandom); x1 = 16'($urandom); y1 = 16'($urandom);
      c = 2'($urandom);
      gexp = (i % 2 == 0) ? 2'b01 : 2'b10;
      start_op(2'b11, x0, y0, x1, y1, c, g, ok);
      checks++;
      if (g !== gexp) begin
        errors++; $display("FAIL arb_grant op%0d got %b want %b", i, g, gexp);
      end
      if (gexp[1]) model(x1, y1, c[1], es, eco, esk);
      else         model(x0, y0, c[0], es, eco, esk);
      wait_result(lat, s, co, id, sk);
      checks++;
      if (lat != N + 1 || s !== es || co !== eco || id !== gexp[1] || sk !== esk) begin
        errors++;
        $display("FAIL arb_result op%0d got lat=%0d sum=%h cout=%b id=%b skip=%0d want lat=%0d sum=%h cout=%b id=%b skip=%0d",
                 i, lat, s, co, id, sk, N + 1, es, eco, gexp[1], esk);
      end
      accept();
    end
    req_valid = 2'b00;
    model_rr = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0] g;
    bit ok;
    int lat;
    logic [WIDTH-1:0] s;
    logic co, id;
    logic [CW-1:0] sk;

    start_op(2'b01, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 2'b00, g, ok);
    req_valid = 2'b00;
    wait_result(lat, s, co, id, sk);
    checks++;
    if (g !== 2'b01 || lat != 5 || s !== 16'h0000 || co !== 1'b1 || sk !== 3'd3 || id !== 1'b0) begin
      errors++;
      $display("FAIL dir_carry_ripple got g=%b lat=%0d sum=%h cout=%b skip=%0d id=%b want g=01 lat=5 sum=0000 cout=1 skip=3 id=0",
               g, lat, s, co, sk, id);
    end
    accept();

    start_op(2'b10, 16'h0000, 16'h0000, 16'h1234, 16'h4321, 2'b10, g, ok);
    req_valid = 2'b00;
    wait_result(lat, s, co, id, sk);
    checks++;
    if (g !== 2'b10 || lat != 5 || s !== 16'h5556 || co !== 1'b0 || sk !== 3'd0 || id !== 1'b1) begin
      errors++;
      $display("FAIL dir_req1 got g=%b lat=%0d sum=%h cout=%b skip=%0d id=%b want g=10 lat=5 sum=5556 cout=0 skip=0 id=1",
               g, lat, s, co, sk, id);
    end
    accept();

    start_op(2'b01, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 2'b01, g, ok);
    req_valid = 2'b00;
    wait_result(lat, s, co, id, sk);
    checks++;
    if (g !== 2'b01 || lat != 5 || s !== 16'h0000 || co !== 1'b1 || sk !== 3'd4 || id !== 1'b0) begin
      errors++;
      $display("FAIL dir_full_skip got g=%b lat=%0d sum=%h cout=%b skip=%0d id=%b want g=01 lat=5 sum=0000 cout=1 skip=4 id=0",
               g, lat, s, co, sk, id);
    end
    accept();
    model_rr = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [1:0] g, c, gexp;
    bit ok;
    int lat;
    logic [WIDTH-1:0] x0, y0, x1, y1, s, es;
    logic co, id, eco;
    logic [CW-1:0] sk, esk;
    x0 = 16'($urandom); y0 = 16'($urandom); x1 = 16'($urandom); y1 = 16'($urandom);
    c = 2'($urandom);
    gexp = model_rr ? 2'b10 : 2'b01;
    if (gexp[1]) model(x1, y1, c[1], es, eco, esk);
    else         model(x0, y0, c[0], es, eco, esk);
    start_op(2'b11, x0, y0, x1, y1, c, g, ok);
    req_valid = 2'b11;
    model_rr = ~gexp[1];
    wait_result(lat, s, co, id, sk);
    checks++;
    if (g !== gexp || lat != N + 1) begin
      errors++; $display("FAIL bp_start got g=%b lat=%0d want g=%b lat=%0d", g, lat, gexp, N + 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || req_ready !== 2'b00 || res_sum !== es || res_cout !== eco ||
          res_id !== gexp[1] || res_skip_cnt !== esk) begin
        errors++;
        $display("FAIL bp_hold cyc%0d got valid=%b ready=%b sum=%h cout=%b id=%b skip=%0d want valid=1 ready=00 sum=%h cout=%b id=%b skip=%0d",
                 i, res_valid, req_ready, res_sum, res_cout, res_id, res_skip_cnt, es, eco, gexp[1], esk);
      end
    end
    accept();
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || req_ready !== ~gexp) begin
      errors++;
      $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=%b", res_valid, req_ready, ~gexp);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid_calc();
    logic [1:0] g;
    bit ok, seen;
    int lat;
    logic [WIDTH-1:0] s, es;
    logic co, id, eco;
    logic [CW-1:0] sk, esk;
    start_op(2'b10, 16'h0000, 16'h0000, 16'h3335, 16'h111A, 2'b10, g, ok);
    req_valid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (g !== 2'b10 || req_ready !== 2'b00 ||
        {res_valid, res_sum, res_cout, res_id, res_skip_cnt} !== '0) begin
      errors++;
      $display("FAIL midcalc_reset got g=%b ready=%b valid=%b sum=%h cout=%b id=%b skip=%0d want g=10 and all 0",
               g, req_ready, res_valid, res_sum, res_cout, res_id, res_skip_cnt);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    req_valid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL midcalc_no_result got res_valid=1 want 0");
    end
    model(16'hBEEF, 16'h4111, 1'b1, es, eco, esk);
    start_op(2'b11, 16'hBEEF, 16'h4111, 16'h0F0F, 16'hF0F0, 2'b11, g, ok);
    req_valid = 2'b00;
    wait_result(lat, s, co, id, sk);
    checks++;
    if (g !== 2'b01 || lat != N + 1 || s !== es || co !== eco || id !== 1'b0 || sk !== esk) begin
      errors++;
      $display("FAIL midcalc_recover got g=%b lat=%0d sum=%h cout=%b id=%b skip=%0d want g=01 lat=%0d sum=%h cout=%b id=0 skip=%0d",
               g, lat, s, co, id, sk, N + 1, es, eco, esk);
    end
    accept();
    model_rr = 1'b1;
  endtask

  task automatic test_random();
    logic [1:0] v, g, c, gexp;
    bit ok;
    int lat, hold;
    logic [WIDTH-1:0] x0, y0, x1, y1, s, es;
    logic co, id, eco;
    logic [CW-1:0] sk, esk;
    for (int i = 0; i < 40; i++) begin
      v = 2'($urandom_range(1, 3));
      x0 = 16'($urandom); y0 = 16'($urandom); x1 = 16'($urandom); y1 = 16'($urandom);
      if (i % 5 == 0) y0 = ~x0;
      c = 2'($urandom);
      gexp = (v == 2'b11) ? (model_rr ? 2'b10 : 2'b01) : v;
      if (gexp[1]) model(x1, y1, c[1], es, eco, esk);
      else         model(x0, y0, c[0], es, eco, esk);
      start_op(v, x0, y0, x1, y1, c, g, ok);
      req_valid = 2'($urandom);
      res_ready = 1'($urandom);
      model_rr = ~gexp[1];
      wait_result(lat, s, co, id, sk);
      checks++;
      if (g !== gexp || lat != N + 1 || s !== es || co !== eco || id !== gexp[1] || sk !== esk) begin
        errors++;
        $display("FAIL rand op%0d got g=%b lat=%0d sum=%h cout=%b id=%b skip=%0d want g=%b lat=%0d sum=%h cout=%b id=%b skip=%0d",
                 i, g, lat, s, co, id, sk, gexp, N + 1, es, eco, gexp[1], esk);
      end
      hold = $urandom_range(0, 2);
      for (int j = 0; j < hold; j++) @(negedge clk);
      accept();
    end
    req_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arbitration();
    test_directed();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
